// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: size codes, bubble control,
// FSM states and the lane helpers used on the store side.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Matches the MEM/WB reset control value so a bubble looks like reset.
    localparam logic [2:0] BUBBLE_CTRL = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } mem_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_enables = 4'b0001 << lane;
            SZ_HALF: byte_enables = 4'b0011 << lane;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_lanes = {4{wdata[7:0]}};
            SZ_HALF: store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half of a bus word and
// extends it to 32 bits.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by sign or zero extension.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (lane)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SZ_BYTE: data = {{24{sign & byte_s[7]}}, byte_s};
            SZ_HALF: data = {{16{sign & half_s[15]}}, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores on a req/ack data bus, stalls upstream until
// the access completes and presents the result to the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [1:0]  size_in,
    input  logic        sign_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] wdata_in,
    input  logic [2:0]  wb_control_in,
    input  logic [31:0] pc_4_in,
    input  logic [4:0]  regdst_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_out,
    output logic        misalign_out,
    output logic [2:0]  control_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] alu_out,
    output logic [31:0] data_out,
    output logic [4:0]  regdst_out
);

    mem_state_t  state_r;
    logic [1:0]  lane_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic [31:0] load_data_r;
    logic [31:0] aligned_s;
    logic        mem_op_s;
    logic        misalign_s;

    assign mem_op_s   = valid_in & (memread_in | memwrite_in);
    assign misalign_s = is_misaligned(size_in, alu_in[1:0]);

    assign pc_4_out   = pc_4_in;
    assign alu_out    = alu_in;
    assign regdst_out = regdst_in;

    mem_stage_load_align u_load_align (
        .rdata (mem_rdata),
        .lane  (lane_r),
        .size  (size_r),
        .sign  (sign_r),
        .data  (aligned_s)
    );

    // Access FSM with registered bus outputs and captured load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0000_0000;
            mem_be      <= 4'b0000;
            mem_wdata   <= 32'h0000_0000;
            lane_r      <= 2'b00;
            size_r      <= SZ_WORD;
            sign_r      <= 1'b0;
            load_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s && !misalign_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite_in;
                        mem_addr  <= {alu_in[31:2], 2'b00};
                        mem_be    <= byte_enables(size_in, alu_in[1:0]);
                        mem_wdata <= store_lanes(size_in, wdata_in);
                        lane_r    <= alu_in[1:0];
                        size_r    <= size_in;
                        sign_r    <= sign_in;
                        state_r   <= ST_ACCESS;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        load_data_r <= mem_we ? 32'h0000_0000 : aligned_s;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r     <= ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall, misalign flag and MEM/WB control/data; reset forces the flags low.
    always_comb begin
        stall_out    = 1'b0;
        misalign_out = 1'b0;
        control_out  = wb_control_in;
        data_out     = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    control_out = BUBBLE_CTRL;
                    if (misalign_s) begin
                        misalign_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end else begin
                    control_out = wb_control_in;
                end
            end
            ST_ACCESS: begin
                stall_out   = 1'b1;
                control_out = BUBBLE_CTRL;
            end
            ST_DONE: begin
                data_out = load_data_r;
            end
            default: begin
                control_out = BUBBLE_CTRL;
            end
        endcase
        if (reset) begin
            stall_out    = 1'b0;
            misalign_out = 1'b0;
        end else begin
            stall_out    = stall_out;
            misalign_out = misalign_out;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage with a byte-addressed memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, memread_in, memwrite_in, sign_in;
    logic [1:0]  size_in;
    logic [31:0] alu_in, wdata_in, pc_4_in;
    logic [2:0]  wb_control_in;
    logic [4:0]  regdst_in;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_out, misalign_out;
    logic [2:0]  control_out;
    logic [31:0] pc_4_out, alu_out, data_out;
    logic [4:0]  regdst_out;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem_bytes [logic [31:0]];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .memread_in(memread_in),
        .memwrite_in(memwrite_in), .size_in(size_in), .sign_in(sign_in),
        .alu_in(alu_in), .wdata_in(wdata_in), .wb_control_in(wb_control_in),
        .pc_4_in(pc_4_in), .regdst_in(regdst_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_out(stall_out), .misalign_out(misalign_out),
        .control_out(control_out), .pc_4_out(pc_4_out), .alu_out(alu_out),
        .data_out(data_out), .regdst_out(regdst_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        if (mem_bytes.exists(a)) return mem_bytes[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] get_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = get_byte(a + k);
        return w;
    endfunction

    task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem_bytes[a + k] = w[8*k +: 8];
    endtask

    // One instruction through the stage, checked against the memory model.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] alu, input logic [31:0] wd,
                          input int wait_n);
        int          n;
        bit          misal, done_seen;
        int          stall_cnt, waits;
        logic [63:0] mask, val;
        logic [31:0] exp_load, exp_wd, word_addr;
        logic [3:0]  exp_be;
        logic [2:0]  ctrl;
        n         = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        misal     = (n == 2 && (alu % 2) != 0) || (n == 4 && (alu % 4) != 0);
        word_addr = alu - (alu % 4);
        ctrl      = 3'($urandom_range(0, 7));
        @(negedge clk);
        valid_in = 1'b1; memread_in = rd; memwrite_in = wr; size_in = sz; sign_in = sg;
        alu_in = alu; wdata_in = wd; wb_control_in = ctrl;
        pc_4_in = $urandom; regdst_in = 5'($urandom_range(0, 31)); mem_ack = 1'b0;
        if (!rd && !wr) begin
            #1;
            check({tag, " alu stall"}, {31'd0, stall_out}, 32'd0);
            check({tag, " alu ctrl"}, {29'd0, control_out}, {29'd0, ctrl});
            check({tag, " alu data"}, data_out, 32'd0);
            check({tag, " alu pass"}, pc_4_out, pc_4_in);
            @(posedge clk); #1;
            check({tag, " alu no req"}, {31'd0, mem_req}, 32'd0);
            return;
        end
        if (misal) begin
            #1;
            check({tag, " misalign"}, {31'd0, misalign_out}, 32'd1);
            check({tag, " mis stall"}, {31'd0, stall_out}, 32'd0);
            check({tag, " mis ctrl"}, {29'd0, control_out}, 32'd1);
            @(posedge clk); #1;
            check({tag, " mis no req"}, {31'd0, mem_req}, 32'd0);
            valid_in = 1'b0;
            #1;
            check({tag, " mis drop"}, {31'd0, misalign_out}, 32'd0);
            return;
        end
        mask   = (64'd1 << (8 * n)) - 64'd1;
        exp_be = 4'(((1 << n) - 1) << (alu % 4));
        exp_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        val    = 64'd0;
        for (int k = 0; k < n; k++) val[8*k +: 8] = get_byte(alu + k);
        if (sg && val[8*n-1]) val = val | ~mask;
        exp_load  = wr ? 32'd0 : val[31:0];
        stall_cnt = 0; waits = 0; done_seen = 0;
        for (int c = 0; c < 64 && !done_seen; c++) begin
            if (c > 0) @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                check({tag, " we"}, {31'd0, mem_we}, {31'd0, wr});
                check({tag, " addr"}, mem_addr, word_addr);
                check({tag, " be"}, {28'd0, mem_be}, {28'd0, exp_be});
                if (wr) check({tag, " wdata"}, mem_wdata, exp_wd);
                if (waits == wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = get_word(word_addr);
                    if (wr) for (int k = 0; k < n; k++) mem_bytes[alu + k] = wd[8*k +: 8];
                end else begin
                    waits++;
                    mem_rdata = $urandom;
                end
            end
            #1;
            if (stall_out) begin
                stall_cnt++;
            end else begin
                done_seen = 1;
                check({tag, " data"}, data_out, exp_load);
                check({tag, " ctrl"}, {29'd0, control_out}, {29'd0, ctrl});
                check({tag, " req done"}, {31'd0, mem_req}, 32'd0);
            end
        end
        check({tag, " finished"}, {31'd0, done_seen}, 32'd1);
        check({tag, " stalls"}, stall_cnt, wait_n + 2);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
        size_in = 2'd0; sign_in = 1'b0; alu_in = 32'd0; wdata_in = 32'd0;
        wb_control_in = 3'd0; pc_4_in = 32'd0; regdst_in = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        #12;
        check("rst req", {31'd0, mem_req}, 32'd0);
        check("rst we", {31'd0, mem_we}, 32'd0);
        check("rst be", {28'd0, mem_be}, 32'd0);
        check("rst stall", {31'd0, stall_out}, 32'd0);
        check("rst misalign", {31'd0, misalign_out}, 32'd0);
        check("rst data", data_out, 32'd0);
        @(negedge clk); reset = 1'b0;

        preload_word(32'h100, 32'hDEADBEEF);
        run_op("wload", 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 0);
        check("wload const", data_out, 32'hDEADBEEF);
        preload_word(32'h100, 32'h80FF_0000);
        run_op("sbload", 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 3);
        check("sbload const", data_out, 32'hFFFFFF80);
        run_op("ubload", 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 3);
        check("ubload const", data_out, 32'h00000080);
        run_op("hstore", 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 1);
        run_op("hload", 1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'd0, 0);
        check("hload const", data_out, 32'h0000ABCD);
        run_op("wmis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 0);

        // Load followed immediately by an ALU op, then a stray ack in IDLE.
        run_op("b2b load", 1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 0);
        run_op("b2b alu", 1'b0, 1'b0, 2'd0, 1'b0, 32'h55, 32'd0, 0);
        @(negedge clk);
        valid_in = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; #1;
        check("stray ack req", {31'd0, mem_req}, 32'd0);
        check("stray ack stall", {31'd0, stall_out}, 32'd0);

        // Abandon an access with reset while the request is outstanding.
        valid_in = 1'b1; memread_in = 1'b1; memwrite_in = 1'b0; size_in = 2'd2; alu_in = 32'h180;
        @(negedge clk); #1;
        check("mid req up", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; #1;
        check("mid rst req", {31'd0, mem_req}, 32'd0);
        check("mid rst stall", {31'd0, stall_out}, 32'd0);
        @(negedge clk); reset = 1'b0; valid_in = 1'b0;
        run_op("post rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h180, 32'd0, 1);

        for (int i = 0; i < 30; i++) begin
            logic wr_r, rd_r;
            wr_r = 1'($urandom_range(0, 1));
            rd_r = wr_r ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 5) != 0);
            run_op("rand", rd_r, wr_r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h300 + 32'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3));
        end
        @(negedge clk); valid_in = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage core; sits between the EX/MEM register and the MEM/WB register.
- Runs loads and stores against a single-port data-memory bus with a req/ack handshake.
- Aligns, sign-extends or zero-extends load data; stalls the upstream pipeline until the access completes.
- Feeds the MEM/WB register: pc_4, load data, ALU result, 3-bit WB control, destination register.

Parameters:
- BUBBLE_CTRL, 3'b001, WB control value driven while stalled or on a misaligned access; equals the MEM/WB reset control value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  EX/MEM holds a live instruction
- memread_in  in  1  load
- memwrite_in  in  1  store
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- sign_in  in  1  1 = sign-extend loads
- alu_in  in  32  ALU result / effective address
- wdata_in  in  32  store data (rt)
- wb_control_in  in  3  WB control from EX/MEM
- pc_4_in  in  32  PC+4
- regdst_in  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({alu[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  read data, valid with mem_ack
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- misalign_out  out  1  one-cycle misaligned-access flag
- control_out  out  3  to MEM/WB
- pc_4_out, alu_out, data_out  out  32  to MEM/WB
- regdst_out  out  5  to MEM/WB

Behaviour:
- Memory op: valid_in & (memread_in | memwrite_in).
- Misaligned: half with alu[0]=1, or word with alu[1:0]≠0.
- FSM states: IDLE, ACCESS, DONE. Reset sends the FSM to IDLE.
- Reset values: mem_req=0, mem_we=0, mem_be=0, stall_out=0, misalign_out=0, captured load data=0.
- Pass-through outputs pc_4_out, alu_out and regdst_out follow their inputs combinationally at all times.
- IDLE, no memory op: control_out=wb_control_in, data_out=0, stall_out=0.
- IDLE, memory op, misaligned: no bus access. misalign_out=1, control_out=BUBBLE_CTRL, no stall, FSM stays in IDLE.
- IDLE, memory op, aligned: stall_out=1 combinationally and control_out=BUBBLE_CTRL. Latch we, addr, be and wdata from the inputs, then go to ACCESS.
- ACCESS: mem_req=1 and bus outputs are held stable. stall_out=1, control_out=BUBBLE_CTRL.
- ACCESS with mem_ack: capture extracted load data (0 for stores) and go to DONE. stall_out stays 1 in the ack cycle.
- DONE: stall_out=0, control_out=wb_control_in, data_out=captured data. Go to IDLE next cycle.
- Upstream must hold all inputs while stall_out=1. The instruction retires into MEM/WB on the DONE edge.
- Minimum memory-op cost is 3 cycles (IDLE, ACCESS, DONE), with 2 stall cycles. Each ack wait cycle adds one.
- The access is never re-issued: DONE always returns to IDLE, even though the same op is still presented during DONE.
- Byte enables (little-endian lanes): byte 4'b0001<<alu[1:0]; half 4'b0011<<alu[1:0]; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction: select the byte or half at lane alu[1:0] of mem_rdata. Extend to 32 bits by sign_in.
- mem_ack outside ACCESS is ignored.
- Reset mid-access: mem_req drops asynchronously and the FSM returns to IDLE. The memory must tolerate an abandoned request.
- memread and memwrite both set: treated as a store.

Decomposition:
- Shared pipeline package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - BUBBLE_CTRL
  - FSM state encodings
- One natural sub-module, load_align: combinational lane select plus sign/zero extension. It is reusable by a future cache refill path.

Test Plan:
- Reset mid-ACCESS: assert reset -> mem_req=0 immediately, stall_out=0. After release, next op starts cleanly from IDLE.
- Word load, alu=0x100, ack in first ACCESS cycle, mem_rdata=0xDEADBEEF:
  - mem_be=4'b1111, stall_out high 2 cycles
  - DONE cycle: data_out=0xDEADBEEF, control_out=wb_control_in
- Signed byte load, alu=0x103, mem_rdata=0x80FF_0000, ack after 3 wait cycles:
  - data_out=0xFFFFFF80, 5 stall cycles
  - same with sign_in=0: data_out=0x00000080
- Half store, alu=0x202, wdata=0x1234ABCD:
  - mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x200
  - DONE cycle: data_out=0
- Word load, alu=0x101:
  - no mem_req, misalign_out=1 for 1 cycle, control_out=3'b001, stall_out=0
- Back-to-back ops, load then non-memory ALU op:
  - ALU op passes with zero stall right after DONE
  - no duplicate mem_req
  - stray mem_ack in IDLE ignored
